// File: rtl/dac_tx.sv
// dac_tx: I2S transmitter for a stereo 24-bit DAC.
// BCLK is divided down from clk_fast.  A 64-slot frame carries the left word
// while dac_lrck is 0 and the right word while it is 1.  Each half-frame is
// laid out as: one leading zero slot, 24 data bits MSB first, 7 zero slots.
// A one-entry pending register decouples the sample source from frame timing;
// a frame that starts with nothing pending sends silence and pulses underrun.
// Optional feature: define DAC_TX_UNDERRUN_CNT_EN to add the saturating
// 16-bit underrun_cnt output.  Without it the port and counter do not exist.
module dac_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk_fast,
    input  logic        rst,
    input  logic [23:0] left_data,
    input  logic [23:0] right_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        dac_bclk,
    output logic        dac_lrck,
    output logic        dac_sdata,
    output logic        underrun
`ifdef DAC_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt_q,     div_cnt_d;
    logic        bclk_q,        bclk_d;
    logic [5:0]  bit_cnt_q,     bit_cnt_d;
    logic        lrck_q,        lrck_d;
    logic        sdata_q,       sdata_d;
    logic        underrun_q,    underrun_d;
    logic        ready_q,       ready_d;
    logic        pend_full_q,   pend_full_d;
    logic [23:0] pend_left_q,   pend_left_d;
    logic [23:0] pend_right_q,  pend_right_d;
    logic [23:0] shift_left_q,  shift_left_d;
    logic [23:0] shift_right_q, shift_right_d;

    logic        div_wrap;
    logic        fall_event;
    logic        frame_load;
    logic        accept;
    logic [5:0]  bit_next;
    logic [4:0]  slot_next;
    logic        data_slot;

    // Strobes derived from the current state: the divider wrap, the BCLK
    // falling edge that moves every serial output, and the frame start.
    always_comb begin
        div_wrap   = (div_cnt_q == DIV_LAST);
        fall_event = div_wrap && bclk_q;
        bit_next   = bit_cnt_q + 6'd1;
        slot_next  = bit_next[4:0];
        data_slot  = (slot_next >= 5'd1) && (slot_next <= 5'd24);
        frame_load = fall_event && (bit_cnt_q == 6'd63);
        accept     = sample_valid && ready_q;
    end

    // Bit-clock divider: BCLK flips each time the divider wraps.
    always_comb begin
        div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
        bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    end

    // Slot counter and word select move together on BCLK falling edges.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        if (fall_event) begin
            bit_cnt_d = bit_next;
            lrck_d    = bit_next[5];
        end
    end

    // Serial data path: a frame start loads both shift registers (silence if
    // nothing is pending); data slots then shift the active channel out MSB
    // first, and all other slots drive 0.
    always_comb begin
        shift_left_d  = shift_left_q;
        shift_right_d = shift_right_q;
        sdata_d       = sdata_q;
        if (frame_load) begin
            shift_left_d  = pend_full_q ? pend_left_q  : 24'h000000;
            shift_right_d = pend_full_q ? pend_right_q : 24'h000000;
            sdata_d       = 1'b0;
        end else if (fall_event) begin
            sdata_d = 1'b0;
            if (data_slot) begin
                if (!bit_next[5]) begin
                    sdata_d      = shift_left_q[23];
                    shift_left_d = {shift_left_q[22:0], 1'b0};
                end else begin
                    sdata_d       = shift_right_q[23];
                    shift_right_d = {shift_right_q[22:0], 1'b0};
                end
            end
        end
    end

    // Pending-pair handshake.  A frame start empties the slot; an accepted
    // pair fills it.  Both cannot happen with the slot full because ready is
    // low then, so an accept on a frame start always belongs to the next frame.
    always_comb begin
        pend_full_d  = pend_full_q;
        pend_left_d  = pend_left_q;
        pend_right_d = pend_right_q;
        if (frame_load && pend_full_q) begin
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_full_d  = 1'b1;
            pend_left_d  = left_data;
            pend_right_d = right_data;
        end
        ready_d    = ~pend_full_d;
        underrun_d = frame_load && !pend_full_q;
    end

    // State register.  Reset parks the slot counter at 63 so that the first
    // falling edge after release is the load for frame 0.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= 8'd0;
            bclk_q        <= 1'b0;
            bit_cnt_q     <= 6'd63;
            lrck_q        <= 1'b0;
            sdata_q       <= 1'b0;
            underrun_q    <= 1'b0;
            ready_q       <= 1'b0;
            pend_full_q   <= 1'b0;
            pend_left_q   <= 24'h000000;
            pend_right_q  <= 24'h000000;
            shift_left_q  <= 24'h000000;
            shift_right_q <= 24'h000000;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            bit_cnt_q     <= bit_cnt_d;
            lrck_q        <= lrck_d;
            sdata_q       <= sdata_d;
            underrun_q    <= underrun_d;
            ready_q       <= ready_d;
            pend_full_q   <= pend_full_d;
            pend_left_q   <= pend_left_d;
            pend_right_q  <= pend_right_d;
            shift_left_q  <= shift_left_d;
            shift_right_q <= shift_right_d;
        end
    end

`ifdef DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] ur_cnt_q, ur_cnt_d;

    // Underrun counter advances with each underrun pulse and sticks at max.
    always_comb begin
        ur_cnt_d = ur_cnt_q;
        if (underrun_d && (ur_cnt_q != 16'hFFFF)) begin
            ur_cnt_d = ur_cnt_q + 16'd1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            ur_cnt_q <= 16'd0;
        end else begin
            ur_cnt_q <= ur_cnt_d;
        end
    end

    assign underrun_cnt = ur_cnt_q;
`endif

    assign sample_ready = ready_q;
    assign dac_bclk     = bclk_q;
    assign dac_lrck     = lrck_q;
    assign dac_sdata    = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_dac_tx.sv
// tb_dac_tx: randomized directed phases for dac_tx with BCLK_DIV = 4.
// The reference model reasons in whole frames.  Frame f loads at clock edge
// 8 + 512*f after reset release.  The edges between two loads form the
// acceptance window for the following frame, and at most one pair can be
// taken per window.  A serial monitor decodes every complete frame from the
// pins and compares it with what the model expects for that frame.
module tb_dac_tx;

    localparam int BCLK_DIV   = 4;
    localparam int FRAME      = 128 * BCLK_DIV;
    localparam int FIRST_LOAD = 2 * BCLK_DIV;

    logic        clk_fast = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] left_data = 24'h0;
    logic [23:0] right_data = 24'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        dac_bclk;
    logic        dac_lrck;
    logic        dac_sdata;
    logic        underrun;
`ifdef DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    dac_tx #(.BCLK_DIV(BCLK_DIV)) dut (
        .clk_fast     (clk_fast),
        .rst          (rst),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dac_bclk     (dac_bclk),
        .dac_lrck     (dac_lrck),
        .dac_sdata    (dac_sdata),
        .underrun     (underrun)
`ifdef DAC_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    // Free-running fast clock.
    always #5 clk_fast = ~clk_fast;

    // Number of clock edges since reset release.
    int cyc;
    always @(posedge clk_fast or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          lastWin;
    bit          expHas [0:15];
    logic [23:0] expL   [0:15];
    logic [23:0] expR   [0:15];
    int          tgt    [0:15];
    logic [23:0] pl     [0:15];
    logic [23:0] pr     [0:15];

    // Monitor state.
    int          riseIdx;
    int          lastRise;
    int          framesDone = 0;
    logic        prevB;
    logic [23:0] wordL;
    logic [23:0] wordR;
    bit          frameOk;
    bit          urStray;
    bit          urSeen [0:15];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    function automatic int windowOf(input int c);
        int w;
        w = (c < FIRST_LOAD) ? 0 : (c - FIRST_LOAD) / FRAME + 1;
        return (w > 15) ? 15 : w;
    endfunction

    // Drive one clock edge and predict sample_ready for it from the window rules.
    task automatic applyStimulus(input bit hold);
        int          c;
        int          w;
        bit          isLoad;
        bit          rdyExp;
        bit          v;
        logic [23:0] l;
        logic [23:0] r;
        @(negedge clk_fast);
        c      = cyc + 1;
        w      = windowOf(c);
        isLoad = (c >= FIRST_LOAD) && ((c - FIRST_LOAD) % FRAME == 0);
        rdyExp = (c != 1) && (lastWin != w) && !(isLoad && (lastWin == w - 1));
        checkOutput("sampleReady", {31'd0, sample_ready}, {31'd0, rdyExp});
        if (hold) begin
            v = 1'b1;
            l = 24'($urandom);
            r = 24'($urandom);
        end else begin
            v = (c == tgt[w]);
            l = pl[w];
            r = pr[w];
        end
        sample_valid = v;
        left_data    = l;
        right_data   = r;
        if (v && rdyExp) begin
            lastWin   = w;
            expHas[w] = 1'b1;
            expL[w]   = l;
            expR[w]   = r;
        end
        @(posedge clk_fast);
    endtask

    task automatic runEdges(input int lastEdge, input bit hold);
        repeat (lastEdge - 1) applyStimulus(hold);
    endtask

    // Run whole frames and check how many were decoded and underrun totals.
    task automatic runPhase(input int nFrames, input bit hold);
        int startFrames;
        int expUr;
        startFrames = framesDone;
        runEdges(FIRST_LOAD + FRAME * nFrames - 1, hold);
        @(negedge clk_fast);
        checkOutput("frameCount", 32'(framesDone - startFrames), 32'(nFrames));
        expUr = 0;
        for (int f = 0; f < nFrames; f++) if (!expHas[f]) expUr++;
`ifdef DAC_TX_UNDERRUN_CNT_EN
        checkOutput("underrunCnt", {16'd0, underrun_cnt}, 32'(expUr));
`endif
    endtask

    task automatic applyReset();
        @(negedge clk_fast);
        rst          = 1'b1;
        sample_valid = 1'b0;
        #1;
        checkOutput("rstAsyncBclk", {31'd0, dac_bclk}, 32'd0);
        checkOutput("rstAsyncSdata", {31'd0, dac_sdata}, 32'd0);
        lastWin = -1;
        for (int i = 0; i < 16; i++) begin
            expHas[i] = 1'b0;
            expL[i]   = 24'h0;
            expR[i]   = 24'h0;
            tgt[i]    = -1;
            pl[i]     = 24'h0;
            pr[i]     = 24'h0;
        end
        repeat (2) @(negedge clk_fast);
        checkOutput("rstBclk", {31'd0, dac_bclk}, 32'd0);
        checkOutput("rstLrck", {31'd0, dac_lrck}, 32'd0);
        checkOutput("rstSdata", {31'd0, dac_sdata}, 32'd0);
        checkOutput("rstUnderrun", {31'd0, underrun}, 32'd0);
        checkOutput("rstReady", {31'd0, sample_ready}, 32'd0);
`ifdef DAC_TX_UNDERRUN_CNT_EN
        checkOutput("rstUnderrunCnt", {16'd0, underrun_cnt}, 32'd0);
`endif
        rst = 1'b0;
    endtask

    // Serial monitor: decodes each complete frame from bclk rising edges and
    // checks it against the model once slot 63 has been seen.
    always @(negedge clk_fast) begin
        int slot;
        int fr;
        if (rst) begin
            riseIdx  = -1;
            prevB    = 1'b0;
            lastRise = 0;
            wordL    = 24'h0;
            wordR    = 24'h0;
            frameOk  = 1'b1;
            urStray  = 1'b0;
            for (int i = 0; i < 16; i++) urSeen[i] = 1'b0;
        end else begin
            if (underrun === 1'b1) begin
                if (cyc >= FIRST_LOAD && (cyc - FIRST_LOAD) % FRAME == 0 &&
                    (cyc - FIRST_LOAD) / FRAME < 16)
                    urSeen[(cyc - FIRST_LOAD) / FRAME] = 1'b1;
                else
                    urStray = 1'b1;
            end
            if (dac_bclk === 1'b1 && prevB === 1'b0) begin
                if (riseIdx >= 0) begin
                    slot = riseIdx % 64;
                    fr   = riseIdx / 64;
                    if (cyc - lastRise != 2 * BCLK_DIV) frameOk = 1'b0;
                    if (dac_lrck !== 1'(slot >= 32)) frameOk = 1'b0;
                    if (slot >= 1 && slot <= 24)
                        wordL = {wordL[22:0], dac_sdata};
                    else if (slot >= 33 && slot <= 56)
                        wordR = {wordR[22:0], dac_sdata};
                    else if (dac_sdata !== 1'b0)
                        frameOk = 1'b0;
                    if (slot == 63 && fr < 16) begin
                        checkOutput("leftWord", {8'd0, wordL},
                                    expHas[fr] ? {8'd0, expL[fr]} : 32'd0);
                        checkOutput("rightWord", {8'd0, wordR},
                                    expHas[fr] ? {8'd0, expR[fr]} : 32'd0);
                        checkOutput("frameTiming", {31'd0, frameOk}, 32'd1);
                        checkOutput("underrunPulse", {31'd0, urSeen[fr]},
                                    {31'd0, !expHas[fr]});
                        checkOutput("underrunStray", {31'd0, urStray}, 32'd0);
                        framesDone++;
                        wordL   = 24'h0;
                        wordR   = 24'h0;
                        frameOk = 1'b1;
                        urStray = 1'b0;
                    end
                end
                riseIdx++;
                lastRise = cyc;
            end
            prevB = dac_bclk;
        end
    end

    initial begin
        // Idle: silent frames, one underrun per frame.
        applyReset();
        runPhase(3, 1'b0);

        // Fixed pattern in frame 0, then random pairs at random window offsets.
        applyReset();
        tgt[0] = FIRST_LOAD - 6 + int'($urandom_range(0, 5));
        pl[0]  = 24'hA5A5A5;
        pr[0]  = 24'h5A5A5A;
        for (int w = 1; w <= 6; w++) begin
            tgt[w] = ($urandom_range(0, 3) == 0) ? -1 :
                     FIRST_LOAD + FRAME * (w - 1) + int'($urandom_range(0, FRAME - 1));
            pl[w]  = 24'($urandom);
            pr[w]  = 24'($urandom);
        end
        runPhase(6, 1'b0);

        // Valid held high with changing data: one pair per frame.
        applyReset();
        runPhase(3, 1'b1);

        // Valid exactly on the frame-0 load with pending empty, then again on
        // the frame-1 load while the slot is full (must be ignored).
        applyReset();
        tgt[1] = FIRST_LOAD;
        pl[1]  = 24'h123456;
        pr[1]  = 24'hFEDCBA;
        tgt[2] = FIRST_LOAD + FRAME;
        pl[2]  = 24'h0F0F0F;
        pr[2]  = 24'hF0F0F0;
        runPhase(3, 1'b0);

        // Reset at slot 40 of frame 0 with a pair pending; it must never appear.
        applyReset();
        tgt[0] = 3;
        pl[0]  = 24'h800001;
        pr[0]  = 24'h7FFFFE;
        tgt[1] = FIRST_LOAD + 100;
        pl[1]  = 24'hC0FFEE;
        pr[1]  = 24'hBADCAF;
        runEdges(FIRST_LOAD + 40 * 2 * BCLK_DIV + 2, 1'b0);
        applyReset();
        runPhase(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
